// File: rtl/auto_decision_pkg.sv
// Shared state/choice codes and timing constants for auto_decision.
// AUTO_DEBOUNCE_EN selects majority-filtered detectors.
package auto_defs;

  localparam int SETTLE_TIME  = 25;
  localparam int FORWARD_TIME = 150;
  localparam int ACK_TIMEOUT  = 10;

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  localparam int CNT_W =
    $clog2(max3(SETTLE_TIME, FORWARD_TIME, ACK_TIMEOUT) + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t SETTLE_LAST = cnt_t'(SETTLE_TIME - 1);
  localparam cnt_t ACK_LAST    = cnt_t'(ACK_TIMEOUT - 1);
  localparam cnt_t FWD_SAT     = cnt_t'(FORWARD_TIME);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETTLE  = 3'd1,
    S_DECIDE  = 3'd2,
    S_TRIG    = 3'd3,
    S_WAIT    = 3'd4,
    S_CRUISE  = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    C_NONE     = 3'd0,
    C_LEFT     = 3'd1,
    C_RIGHT    = 3'd2,
    C_BACK     = 3'd3,
    C_STRAIGHT = 3'd4
  } choice_e;

  typedef struct packed {
    logic front;
    logic left;
    logic right;
  } det_t;

  // Left-wall following: prefer left, then straight, then right.
  function automatic choice_e pick_move(det_t d);
    if (!d.left)  return C_LEFT;
    if (!d.front) return C_STRAIGHT;
    if (!d.right) return C_RIGHT;
    return C_BACK;
  endfunction

endpackage

// File: rtl/detector_debounce.sv
// Per-bit 3-sample majority filter for the obstacle detectors.
// Only built when AUTO_DEBOUNCE_EN is defined.
`ifdef AUTO_DEBOUNCE_EN
module detector_debounce #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] raw_i,
  output logic [W-1:0] filt_o
);

  logic [W-1:0] s0_q, s1_q, s2_q;
  logic [W-1:0] s0_d, s1_d, s2_d;

  always_comb begin
    s0_d = raw_i;
    s1_d = s0_q;
    s2_d = s1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_q <= '0;
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s0_q <= s0_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign filt_o = (s0_q & s1_q) | (s0_q & s2_q) | (s1_q & s2_q);

endmodule
`endif

// File: rtl/auto_decision.sv
// Left-wall-following decision FSM feeding the turn executor.
// AUTO_DEBOUNCE_EN inserts a majority filter on the detectors.
module auto_decision
  import auto_defs::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       detector_front,
  input  logic       detector_left,
  input  logic       detector_right,
  input  logic       is_turning,
  output logic       trigger_turn_left,
  output logic       trigger_turn_right,
  output logic       trigger_turn_back,
  output logic       move_forward,
  output logic       decision_err,
  output logic [2:0] state_dbg
);

  state_e  state_q, state_d;
  cnt_t    cnt_q, cnt_d;
  choice_e choice_q, choice_d;
  logic    err_q, err_d;
  det_t    det_raw, det;

  assign det_raw = {detector_front, detector_left, detector_right};

`ifdef AUTO_DEBOUNCE_EN
  detector_debounce #(.W(3)) u_debounce (
    .clk    (clk),
    .rst    (rst),
    .raw_i  (det_raw),
    .filt_o (det)
  );
`else
  assign det = det_raw;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    choice_d = choice_q;
    err_d    = 1'b0;
    if (!enable) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      choice_d = C_NONE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_SETTLE;
          cnt_d   = '0;
        end
        S_SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            state_d = S_DECIDE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + cnt_t'(1);
          end
        end
        S_DECIDE: begin
          choice_d = pick_move(det);
          cnt_d    = '0;
          state_d  = (choice_d == C_STRAIGHT) ? S_CRUISE : S_TRIG;
        end
        S_TRIG: begin
          if (is_turning) begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end else if (cnt_q == ACK_LAST) begin
            state_d = S_SETTLE;
            cnt_d   = '0;
            err_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + cnt_t'(1);
          end
        end
        S_WAIT: begin
          if (!is_turning) begin
            state_d = S_CRUISE;
            cnt_d   = '0;
          end
        end
        S_CRUISE: begin
          // Counter parks at saturation; only then may detectors end the run.
          if (cnt_q == FWD_SAT) begin
            if (det.front | ~det.left) begin
              state_d = S_SETTLE;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = cnt_q + cnt_t'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      choice_q <= C_NONE;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      choice_q <= choice_d;
      err_q    <= err_d;
    end
  end

  logic in_trig;
  assign in_trig = (state_q == S_TRIG);

  assign trigger_turn_left  = in_trig && (choice_q == C_LEFT);
  assign trigger_turn_right = in_trig && (choice_q == C_RIGHT);
  assign trigger_turn_back  = in_trig && (choice_q == C_BACK);
  assign move_forward       = (state_q == S_CRUISE);
  assign decision_err       = err_q;
  assign state_dbg          = state_q;

endmodule

// File: tb/tb_auto_decision.sv
// Random + directed bench for auto_decision against a phase/elapsed-time model.
// Define AUTO_DEBOUNCE_EN to exercise the filtered build.
module tb_auto_decision;

  localparam int SETTLE = 25;
  localparam int FWD    = 150;
  localparam int ACK    = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enable = 1'b0;
  logic detector_front = 1'b0;
  logic detector_left = 1'b0;
  logic detector_right = 1'b0;
  logic is_turning = 1'b0;
  logic trigger_turn_left, trigger_turn_right, trigger_turn_back;
  logic move_forward, decision_err;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  auto_decision dut (
    .clk                (clk),
    .rst                (rst),
    .enable             (enable),
    .detector_front     (detector_front),
    .detector_left      (detector_left),
    .detector_right     (detector_right),
    .is_turning         (is_turning),
    .trigger_turn_left  (trigger_turn_left),
    .trigger_turn_right (trigger_turn_right),
    .trigger_turn_back  (trigger_turn_back),
    .move_forward       (move_forward),
    .decision_err       (decision_err),
    .state_dbg          (state_dbg)
  );

  always #5 clk = ~clk;

  // Model: phase 0 idle,1 settle,2 decide,3 trigger,4 wait,5 cruise.
  // pick: 1 left, 2 right, 3 back, 4 straight.
  int m_ph = 0;
  int m_age = 0;
  int m_pick = 0;
  bit m_err = 0;
  logic [2:0] h1 = '0, h2 = '0, h3 = '0;
  logic [2:0] seen;

  function automatic logic [2:0] maj(logic [2:0] a, logic [2:0] b,
                                     logic [2:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph = 0; m_age = 0; m_pick = 0; m_err = 0;
      h1 = '0; h2 = '0; h3 = '0;
    end else begin
      cyc++;
`ifdef AUTO_DEBOUNCE_EN
      seen = maj(h1, h2, h3);
      h3 = h2; h2 = h1;
      h1 = {detector_front, detector_left, detector_right};
`else
      seen = {detector_front, detector_left, detector_right};
`endif
      m_err = 0;
      if (!enable) begin
        m_ph = 0; m_age = 0; m_pick = 0;
      end else begin
        case (m_ph)
          0: begin m_ph = 1; m_age = 0; end
          1: begin
            m_age++;
            if (m_age == SETTLE) begin m_ph = 2; m_age = 0; end
          end
          2: begin
            if (!seen[1])      begin m_pick = 1; m_ph = 3; end
            else if (!seen[2]) begin m_pick = 4; m_ph = 5; end
            else if (!seen[0]) begin m_pick = 2; m_ph = 3; end
            else               begin m_pick = 3; m_ph = 3; end
            m_age = 0;
          end
          3: begin
            if (is_turning) begin m_ph = 4; m_age = 0; end
            else begin
              m_age++;
              if (m_age == ACK) begin m_ph = 1; m_age = 0; m_err = 1; end
            end
          end
          4: if (!is_turning) begin m_ph = 5; m_age = 0; end
          5: begin
            if (m_age >= FWD && (seen[2] || !seen[1])) begin
              m_ph = 1; m_age = 0;
            end else if (m_age < FWD) m_age++;
          end
          default: m_ph = 0;
        endcase
      end
    end
  end

  logic [7:0] got_v, exp_v;
  always @(negedge clk) begin
    if (!rst) begin
      got_v = {trigger_turn_left, trigger_turn_right, trigger_turn_back,
               move_forward, decision_err, state_dbg};
      exp_v = {m_ph == 3 && m_pick == 1, m_ph == 3 && m_pick == 2,
               m_ph == 3 && m_pick == 3, m_ph == 5, m_err, 3'(m_ph)};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL model cycle %0d got=%b exp=%b (l r b fwd err st)",
                 cyc, got_v, exp_v);
      end
    end
  end

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    enable = 1'b0;
    is_turning = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_det(logic f, logic l, logic r);
    detector_front = f;
    detector_left  = l;
    detector_right = r;
  endtask

  task automatic edges(int n);
    repeat (n) @(negedge clk);
  endtask

  int pend = 0, dly = 0, busy = 0;

  initial begin
    #1 rst = 1'b1;
    #2;
    chk("reset_state", state_dbg, 0);
    chk("reset_outs", {trigger_turn_left, trigger_turn_right,
                       trigger_turn_back, move_forward, decision_err}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Right turn, ack, cruise, then async reset mid-cruise.
    do_reset();
    set_det(1, 1, 0);
    enable = 1'b1;
    edges(26);
    chk("pre_trig_right", trigger_turn_right, 0);
    edges(1);
    chk("trig_right", trigger_turn_right, 1);
    chk("trig_state", state_dbg, 3);
    is_turning = 1'b1;
    edges(1);
    chk("ack_drops_trig", trigger_turn_right, 0);
    chk("wait_state", state_dbg, 4);
    is_turning = 1'b0;
    edges(1);
    chk("cruise_after_turn", move_forward, 1);
    #1 rst = 1'b1;
    #1 chk("async_rst_cruise", {move_forward, state_dbg}, 0);
    @(negedge clk);
    rst = 1'b0;

    // All blocked -> back only; async reset mid-trigger.
    set_det(1, 1, 1);
    enable = 1'b1;
    edges(27);
    chk("trig_back_onehot", {trigger_turn_left, trigger_turn_right,
                             trigger_turn_back}, 3'b001);
    #1 rst = 1'b1;
    #1 chk("async_rst_trig", trigger_turn_back, 0);
    @(negedge clk);
    rst = 1'b0;

    // Left beats front/right; drop enable mid-wait.
    set_det(1, 0, 1);
    enable = 1'b1;
    edges(27);
    chk("trig_left_onehot", {trigger_turn_left, trigger_turn_right,
                             trigger_turn_back}, 3'b100);
    is_turning = 1'b1;
    edges(2);
    chk("hold_wait", state_dbg, 4);
    enable = 1'b0;
    edges(1);
    chk("enable_drop_idle", state_dbg, 0);
    is_turning = 1'b0;

    // Straight, minimum cruise, then front blocked ends the run.
    do_reset();
    set_det(0, 1, 0);
    enable = 1'b1;
    edges(27);
    chk("straight_no_trig", {trigger_turn_left, trigger_turn_right,
                             trigger_turn_back, move_forward}, 4'b0001);
    set_det(1, 1, 0);
    edges(150);
    chk("cruise_min_hold", move_forward, 1);
    edges(1);
    chk("cruise_exit_fwd", move_forward, 0);
    chk("cruise_exit_state", state_dbg, 1);

    // Ack timeout.
    do_reset();
    set_det(1, 1, 1);
    enable = 1'b1;
    edges(36);
    chk("trig_held_10th", trigger_turn_back, 1);
    edges(1);
    chk("timeout_err", decision_err, 1);
    chk("timeout_trig_low", trigger_turn_back, 0);
    chk("timeout_state", state_dbg, 1);
    edges(1);
    chk("err_one_cycle", decision_err, 0);

    // is_turning already high on TRIG entry is an immediate ack.
    do_reset();
    set_det(1, 1, 0);
    is_turning = 1'b1;
    enable = 1'b1;
    edges(28);
    chk("early_ack_wait", state_dbg, 4);
    is_turning = 1'b0;

`ifdef AUTO_DEBOUNCE_EN
    // One-cycle left glitch right at the decide sample is filtered.
    do_reset();
    set_det(1, 1, 0);
    enable = 1'b1;
    edges(26);
    detector_left = 1'b0;
    edges(1);
    detector_left = 1'b1;
    chk("glitch_filtered", {trigger_turn_left, trigger_turn_right}, 2'b01);
`endif

    // Random traffic with a loosely modelled executor.
    do_reset();
    enable = 1'b1;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0)
        {detector_front, detector_left, detector_right} = 3'($urandom);
      if (enable) enable = ($urandom_range(0, 399) != 0);
      else        enable = ($urandom_range(0, 4) == 0);
      if (busy > 0) begin
        busy--;
        is_turning = (busy != 0);
      end else if (pend != 0) begin
        if (dly == 0) begin
          busy = $urandom_range(1, 6);
          is_turning = 1'b1;
          pend = 0;
        end else dly--;
      end else if (trigger_turn_left | trigger_turn_right |
                   trigger_turn_back) begin
        pend = 1;
        dly = $urandom_range(0, 12);
      end else begin
        is_turning = ($urandom_range(0, 40) == 0);
      end
      if ($urandom_range(0, 1499) == 0) begin
        #1 rst = 1'b1;
        #2 rst = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
